// File: rtl/lane_pkg.sv
// Shared definitions for the byte-lane sequencer: widths, size encodings, FSM states
// and the size-to-byte-count helper.
package lane_pkg;

    localparam int dataWidth    = 8;
    localparam int addressWidth = 32;
    localparam int wordBytes    = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } laneState_t;

    // Encoding 2'b11 is an alias for a word access.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_sequencer_if.sv
// Core request/response and byte-memory signals of the sequencer, bundled in one interface.
interface byte_lane_sequencer_if;
    import lane_pkg::*;

    logic                     reqValid;
    logic                     reqReady;
    logic                     reqWrite;
    logic [1:0]               reqSize;
    logic                     reqSigned;
    logic [addressWidth-1:0]  reqAddr;
    logic [8*wordBytes-1:0]   reqWData;
    logic                     rspValid;
    logic [8*wordBytes-1:0]   rspRData;
    logic                     memWrite;
    logic [addressWidth-1:0]  memAddr;
    logic [dataWidth-1:0]     memWData;
    logic [dataWidth-1:0]     memRData;

    // The master side plays both the core and the memory.
    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData, memRData,
        input  reqReady, rspValid, rspRData, memWrite, memAddr, memWData
    );

    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData, memRData,
        output reqReady, rspValid, rspRData, memWrite, memAddr, memWData
    );

endinterface

// File: rtl/load_extend.sv
// Sign- or zero-extends a 1/2/4-byte little-endian load value to a full 32-bit word.
module load_extend (
    input  logic [31:0] raw,
    input  logic [2:0]  nBytes,
    input  logic        isSigned,
    output logic [31:0] extended
);

    always_comb begin
        case (nBytes)
            3'd1:    extended = {{24{isSigned & raw[7]}}, raw[7:0]};
            3'd2:    extended = {{16{isSigned & raw[15]}}, raw[15:0]};
            default: extended = raw;
        endcase
    end

endmodule

// File: rtl/byte_lane_sequencer.sv
// Splits byte/half/word loads and stores into sequential single-byte memory accesses
// (little-endian) and returns extended load data to the core.
module byte_lane_sequencer
    import lane_pkg::*;
(
    input  logic clk,
    input  logic rstN,
    byte_lane_sequencer_if.slave bus
);

    laneState_t             state;
    laneState_t             stateNext;
    logic [1:0]             cnt;
    logic [2:0]             nBytesQ;
    logic                   writeQ;
    logic                   signedQ;
    logic [8*wordBytes-1:0] wdataQ;
    logic [8*wordBytes-1:0] rdataQ;
    logic [8*wordBytes-1:0] rdataMerged;
    logic [8*wordBytes-1:0] extended;
    logic                   accept;
    logic                   lastByte;

    assign bus.reqReady = (state == IDLE) && rstN;
    assign accept       = bus.reqValid && bus.reqReady;
    assign lastByte     = (state == XFER) && ({1'b0, cnt} == nBytesQ - 3'd1);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = XFER;
            XFER:    if (lastByte) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // The final load byte is merged in here so the response can be formed on the same edge.
    always_comb begin
        rdataMerged = rdataQ;
        if (!writeQ) begin
            rdataMerged[{cnt, 3'b000} +: 8] = bus.memRData;
        end
    end

    load_extend extendUnit (
        .raw     (rdataMerged),
        .nBytes  (nBytesQ),
        .isSigned(signedQ),
        .extended(extended)
    );

    // Memory outputs are registered and pre-loaded one cycle ahead of each byte slot,
    // so the level-sensitive write strobe never sees decode glitches.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt          <= '0;
            nBytesQ      <= '0;
            writeQ       <= 1'b0;
            signedQ      <= 1'b0;
            wdataQ       <= '0;
            rdataQ       <= '0;
            bus.rspValid <= 1'b0;
            bus.rspRData <= '0;
            bus.memWrite <= 1'b0;
            bus.memAddr  <= '0;
            bus.memWData <= '0;
        end else begin
            bus.rspValid <= 1'b0;
            if (accept) begin
                cnt          <= '0;
                nBytesQ      <= size_to_nbytes(bus.reqSize);
                writeQ       <= bus.reqWrite;
                signedQ      <= bus.reqSigned;
                wdataQ       <= bus.reqWData;
                rdataQ       <= '0;
                bus.memWrite <= bus.reqWrite;
                bus.memAddr  <= bus.reqAddr;
                bus.memWData <= bus.reqWData[7:0];
            end else if (state == XFER) begin
                rdataQ <= rdataMerged;
                if (lastByte) begin
                    bus.memWrite <= 1'b0;
                    bus.rspValid <= 1'b1;
                    bus.rspRData <= writeQ ? '0 : extended;
                end else begin
                    cnt          <= cnt + 2'd1;
                    bus.memAddr  <= bus.memAddr + 1'b1;
                    bus.memWData <= wdataQ[{cnt + 2'd1, 3'b000} +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_lane_sequencer.sv
// Directed self-checking bench for byte_lane_sequencer with a 256-byte memory model.
module tb_byte_lane_sequencer;
    import lane_pkg::*;

    logic clk;
    logic rstN;
    int   checkCount;
    int   passCount;

    logic [7:0]  mem [0:255];
    logic        pokeEn;
    logic [7:0]  pokeAddr;
    logic [7:0]  pokeData;
    logic        clearEn;

    logic [31:0] seenAddr  [0:7];
    logic [7:0]  seenWData [0:7];
    logic        seenWrite [0:7];
    int          nSeen;
    logic        anyReady;

    logic [31:0] rdata;
    int          latency;
    logic        sawRsp;

    byte_lane_sequencer_if bus ();

    byte_lane_sequencer dut (
        .clk (clk),
        .rstN(rstN),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on the clock edge while the strobe is high.
    assign bus.memRData = mem[bus.memAddr[7:0]];

    always @(posedge clk) begin
        if (clearEn) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (pokeEn) begin
            mem[pokeAddr] <= pokeData;
        end else if (bus.memWrite) begin
            mem[bus.memAddr[7:0]] <= bus.memWData;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pokeMem(input logic [7:0] a, input logic [7:0] d);
        pokeEn   = 1'b1;
        pokeAddr = a;
        pokeData = d;
        @(posedge clk);
        #1 pokeEn = 1'b0;
    endtask

    task automatic driveRequest(input logic w, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata);
        bus.reqValid  = 1'b1;
        bus.reqWrite  = w;
        bus.reqSize   = size;
        bus.reqSigned = sgn;
        bus.reqAddr   = addr;
        bus.reqWData  = wdata;
    endtask

    // Called at the negedge of the first XFER cycle; records each byte slot until rspValid.
    task automatic collectResponse(output logic [31:0] rd, output int lat);
        lat      = 0;
        rd       = '0;
        nSeen    = 0;
        anyReady = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.reqReady) anyReady = 1'b1;
            if (bus.rspValid) begin
                lat = k;
                rd  = bus.rspRData;
                break;
            end
            if (nSeen < 8) begin
                seenAddr[nSeen]  = bus.memAddr;
                seenWData[nSeen] = bus.memWData;
                seenWrite[nSeen] = bus.memWrite;
                nSeen++;
            end
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        driveRequest(w, size, sgn, addr, wdata);
        @(posedge clk);
        @(negedge clk);
        bus.reqValid = 1'b0;
        collectResponse(rdata, latency);
    endtask

    initial begin
        checkCount    = 0;
        passCount     = 0;
        pokeEn        = 1'b0;
        pokeAddr      = '0;
        pokeData      = '0;
        clearEn       = 1'b1;
        rstN          = 1'b0;
        bus.reqValid  = 1'b0;
        bus.reqWrite  = 1'b0;
        bus.reqSize   = SZ_BYTE;
        bus.reqSigned = 1'b0;
        bus.reqAddr   = '0;
        bus.reqWData  = '0;
        repeat (2) @(negedge clk);
        clearEn = 1'b0;

        // Reset state
        checkOutput("rstReqReady", {31'b0, bus.reqReady}, 32'd0);
        checkOutput("rstMemWrite", {31'b0, bus.memWrite}, 32'd0);
        checkOutput("rstRspValid", {31'b0, bus.rspValid}, 32'd0);
        checkOutput("rstMemAddr", bus.memAddr, 32'd0);
        checkOutput("rstRspRData", bus.rspRData, 32'd0);
        rstN = 1'b1;
        #1 checkOutput("readyAfterRst", {31'b0, bus.reqReady}, 32'd1);

        // 1. Word store 0xA1B2C3D4 @0x10
        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hA1B2C3D4);
        checkOutput("st.latency", latency, 32'd5);
        checkOutput("st.rdata", rdata, 32'd0);
        checkOutput("st.nSeen", nSeen, 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("st.addr%0d", i), seenAddr[i], 32'h10 + i);
            checkOutput($sformatf("st.write%0d", i), {31'b0, seenWrite[i]}, 32'd1);
        end
        checkOutput("st.wdata0", {24'b0, seenWData[0]}, 32'hD4);
        checkOutput("st.wdata1", {24'b0, seenWData[1]}, 32'hC3);
        checkOutput("st.wdata2", {24'b0, seenWData[2]}, 32'hB2);
        checkOutput("st.wdata3", {24'b0, seenWData[3]}, 32'hA1);
        checkOutput("st.memWriteResp", {31'b0, bus.memWrite}, 32'd0);
        checkOutput("st.memAddrHold", bus.memAddr, 32'h13);
        @(negedge clk);
        checkOutput("st.rspPulse", {31'b0, bus.rspValid}, 32'd0);
        checkOutput("st.mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hA1B2C3D4);

        // 2. Half loads @0x21 spanning 0x80, 0xFF
        pokeMem(8'h21, 8'h80);
        pokeMem(8'h22, 8'hFF);
        applyStimulus(1'b0, SZ_HALF, 1'b1, 32'h21, 32'h0);
        checkOutput("lhs.latency", latency, 32'd3);
        checkOutput("lhs.rdata", rdata, 32'hFFFFFF80);
        checkOutput("lhs.noWrite", {31'b0, seenWrite[0] | seenWrite[1]}, 32'd0);
        applyStimulus(1'b0, SZ_HALF, 1'b0, 32'h21, 32'h0);
        checkOutput("lhu.rdata", rdata, 32'h0000FF80);

        // 3. Signed byte loads, both sides of the sign bit
        pokeMem(8'h30, 8'h7F);
        pokeMem(8'h31, 8'h80);
        applyStimulus(1'b0, SZ_BYTE, 1'b1, 32'h30, 32'h0);
        checkOutput("lb7f.latency", latency, 32'd2);
        checkOutput("lb7f.rdata", rdata, 32'h0000007F);
        applyStimulus(1'b0, SZ_BYTE, 1'b1, 32'h31, 32'h0);
        checkOutput("lb80.rdata", rdata, 32'hFFFFFF80);

        // 4. Word load wrapping past the top of the address space (size 11 alias)
        pokeMem(8'hFE, 8'h11);
        pokeMem(8'hFF, 8'h22);
        pokeMem(8'h00, 8'h33);
        pokeMem(8'h01, 8'h44);
        applyStimulus(1'b0, 2'b11, 1'b1, 32'hFFFFFFFE, 32'h0);
        checkOutput("wrap.latency", latency, 32'd5);
        checkOutput("wrap.addr0", seenAddr[0], 32'hFFFFFFFE);
        checkOutput("wrap.addr1", seenAddr[1], 32'hFFFFFFFF);
        checkOutput("wrap.addr2", seenAddr[2], 32'h00000000);
        checkOutput("wrap.addr3", seenAddr[3], 32'h00000001);
        checkOutput("wrap.rdata", rdata, 32'h44332211);

        // 5. Reset asserted after the second byte of a word store
        pokeMem(8'h40, 8'h00);
        pokeMem(8'h41, 8'h00);
        pokeMem(8'h42, 8'h00);
        pokeMem(8'h43, 8'h00);
        @(negedge clk);
        driveRequest(1'b1, SZ_WORD, 1'b0, 32'h40, 32'h55667788);
        @(posedge clk);
        @(negedge clk);
        bus.reqValid = 1'b0;
        @(negedge clk);
        checkOutput("abort.addrByte1", bus.memAddr, 32'h41);
        @(posedge clk);
        #1 rstN = 1'b0;
        #1;
        checkOutput("abort.memWrite", {31'b0, bus.memWrite}, 32'd0);
        checkOutput("abort.memAddr", bus.memAddr, 32'd0);
        checkOutput("abort.memWData", {24'b0, bus.memWData}, 32'd0);
        checkOutput("abort.rspValid", {31'b0, bus.rspValid}, 32'd0);
        checkOutput("abort.reqReadyLow", {31'b0, bus.reqReady}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        #1 checkOutput("abort.reqReady", {31'b0, bus.reqReady}, 32'd1);
        sawRsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rspValid) sawRsp = 1'b1;
        end
        checkOutput("abort.noRsp", {31'b0, sawRsp}, 32'd0);
        checkOutput("abort.mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h00007788);

        // 6. Request held with new fields while busy
        pokeMem(8'h50, 8'h01);
        pokeMem(8'h51, 8'h02);
        pokeMem(8'h52, 8'h03);
        pokeMem(8'h53, 8'h04);
        @(negedge clk);
        driveRequest(1'b0, SZ_WORD, 1'b0, 32'h50, 32'h0);
        @(posedge clk);
        @(negedge clk);
        driveRequest(1'b0, SZ_BYTE, 1'b1, 32'h31, 32'hDEADBEEF);
        collectResponse(rdata, latency);
        checkOutput("busy.readyLow", {31'b0, anyReady}, 32'd0);
        checkOutput("busy.latency", latency, 32'd5);
        checkOutput("busy.rdata", rdata, 32'h04030201);
        checkOutput("busy.addr3", seenAddr[3], 32'h53);
        @(negedge clk);
        checkOutput("busy.readyAgain", {31'b0, bus.reqReady}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.reqValid = 1'b0;
        collectResponse(rdata, latency);
        checkOutput("second.latency", latency, 32'd2);
        checkOutput("second.rdata", rdata, 32'hFFFFFF80);

        @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
